// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port req/ack arbiter and sequencer for a single-port RAM.
// Port 0 (CPU) and port 1 (loader/DMA) share the RAM; each granted access runs
// IDLE -> ACCESS (ACCESS_CYCLES cycles with ram_enable high) -> RESP (ack pulse).
// Optional build macro: RAM_ARB_FIXED_PRIO_EN gives port 0 absolute priority on
// simultaneous requests. When it is undefined, arbitration is round-robin.
module ram_arbiter #(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 4,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                grant_reg, grant_next;         // port owning the current access
  logic                last_grant_reg, last_grant_next;
  logic                we_reg, we_next;               // latched request attributes
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                drive_reg, drive_next;         // arbiter owns the data bus
  logic                ram_enable_reg, ram_enable_next;
  logic                ram_we_reg, ram_we_next;
  logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
  logic                ack0_reg, ack0_next;
  logic                ack1_reg, ack1_next;
  logic [DATA_W-1:0]   rdata0_reg, rdata0_next;
  logic [DATA_W-1:0]   rdata1_reg, rdata1_next;
  logic                busy_reg, busy_next;
  logic                winner;

  // Pick which requester wins when the FSM is idle.
  always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    winner = !req0;
`else
    winner = (req0 && req1) ? !last_grant_reg : req1;
`endif
  end

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    we_next         = we_reg;
    wdata_next      = wdata_reg;
    drive_next      = drive_reg;
    ram_enable_next = ram_enable_reg;
    ram_we_next     = ram_we_reg;
    ram_addr_next   = ram_addr_reg;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    rdata0_next     = rdata0_reg;
    rdata1_next     = rdata1_reg;

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          grant_next      = winner;
          last_grant_next = winner;
          we_next         = winner ? we1 : we0;
          wdata_next      = winner ? wdata1 : wdata0;
          cnt_next        = 4'(ACCESS_CYCLES - 1);
          ram_enable_next = 1'b1;
          ram_we_next     = winner ? we1 : we0;
          ram_addr_next   = winner ? addr1 : addr0;
          drive_next      = winner ? we1 : we0;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          // Last access cycle: sample read data, release the RAM and the bus.
          ram_enable_next = 1'b0;
          ram_we_next     = 1'b0;
          drive_next      = 1'b0;
          ack0_next       = !grant_reg;
          ack1_next       = grant_reg;
          if (!we_reg) begin
            if (grant_reg) begin
              rdata1_next = ram_data;
            end else begin
              rdata0_next = ram_data;
            end
          end
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next      = IDLE;
        ram_enable_next = 1'b0;
        ram_we_next     = 1'b0;
        drive_next      = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and output registers; an active-low reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      drive_reg      <= 1'b0;
      ram_enable_reg <= 1'b0;
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= '0;
      ack0_reg       <= 1'b0;
      ack1_reg       <= 1'b0;
      rdata0_reg     <= '0;
      rdata1_reg     <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      drive_reg      <= drive_next;
      ram_enable_reg <= ram_enable_next;
      ram_we_reg     <= ram_we_next;
      ram_addr_reg   <= ram_addr_next;
      ack0_reg       <= ack0_next;
      ack1_reg       <= ack1_next;
      rdata0_reg     <= rdata0_next;
      rdata1_reg     <= rdata1_next;
      busy_reg       <= busy_next;
    end
  end

  assign ack0             = ack0_reg;
  assign ack1             = ack1_reg;
  assign rdata0           = rdata0_reg;
  assign rdata1           = rdata1_reg;
  assign ram_enable       = ram_enable_reg;
  assign ram_write_enable = ram_we_reg;
  assign ram_addr         = ram_addr_reg;
  assign busy             = busy_reg;
  // Bus is driven only during a write access; the RAM owns it during reads.
  assign ram_data         = drive_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int lanes_done = 0;

  task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, lane, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name, input int lane);
    n_checks++;
    n_fail++;
    $display("FAIL %s lane%0d: timed out waiting for DUT at %0t", name, lane, $time);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam int AC = (gi == 0) ? 1 : 3;

      logic              rst_n, req0, req1, we0, we1;
      logic [ADDR_W-1:0] addr0, addr1, ram_addr;
      logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1;
      logic              ack0, ack1, ram_enable, ram_write_enable, busy;
      wire  [DATA_W-1:0] ram_data;
      logic [DATA_W-1:0] ram_mem [0:4095] = '{default: '0};

      ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(AC)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_enable(ram_enable), .ram_write_enable(ram_write_enable),
        .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
      );

      // Simple RAM: drives on enabled reads, writes on enabled write edges.
      assign ram_data = (ram_enable && !ram_write_enable) ? ram_mem[ram_addr] : 4'bzzzz;
      always @(posedge clk) if (ram_enable && ram_write_enable) ram_mem[ram_addr] <= ram_data;

      // Reference model: one outstanding operation, timed by edges since grant.
      bit                m_op, m_port, m_we, m_last;
      int                m_k;
      logic [ADDR_W-1:0] m_addr;
      logic [DATA_W-1:0] m_wdata;
      logic [DATA_W-1:0] m_rdata [2];
      logic [DATA_W-1:0] m_mem [0:4095] = '{default: '0};

      always @(posedge clk) begin : model
        bit w;
        if (!rst_n) begin
          m_op = 0; m_k = 0; m_last = 1;
          m_rdata[0] = '0; m_rdata[1] = '0;
        end else begin
          if (m_op) begin
            m_k++;
            if (m_k == AC && !m_we) m_rdata[m_port] = m_mem[m_addr];
            if (m_k == AC + 2) m_op = 0;
          end
          if (!m_op && (req0 || req1)) begin
            if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
              w = 0;
`else
              w = (m_last == 1) ? 0 : 1;
`endif
            end else begin
              w = req1 ? 1 : 0;
            end
            m_op = 1; m_k = 0; m_port = w; m_last = w;
            m_we    = w ? we1 : we0;
            m_addr  = w ? addr1 : addr0;
            m_wdata = w ? wdata1 : wdata0;
            if (m_we) m_mem[m_addr] = m_wdata;
          end
        end
      end

      // Compare DUT outputs with the model on every falling edge.
      always @(negedge clk) begin : compare
        bit e_en;
        e_en = m_op && (m_k < AC);
        check("busy",   gi, 32'(busy),             32'(m_op && m_k <= AC));
        check("enable", gi, 32'(ram_enable),       32'(e_en));
        check("wr_en",  gi, 32'(ram_write_enable), 32'(e_en && m_we));
        check("ack0",   gi, 32'(ack0),             32'(m_op && m_k == AC && m_port == 0));
        check("ack1",   gi, 32'(ack1),             32'(m_op && m_k == AC && m_port == 1));
        check("rdata0", gi, 32'(rdata0),           32'(m_rdata[0]));
        check("rdata1", gi, 32'(rdata1),           32'(m_rdata[1]));
        if (e_en) begin
          check("ram_addr", gi, 32'(ram_addr), 32'(m_addr));
          check("bus", gi, 32'(ram_data), m_we ? 32'(m_wdata) : 32'(m_mem[m_addr]));
        end
      end

      // One port-0/1 access from an idle DUT; reports latency and enable cycles.
      task automatic access(input bit p, input bit we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, output int lat, output int en,
                            output logic [DATA_W-1:0] rd);
        bit got;
        got = 0; lat = 0; en = 0; rd = '0;
        if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        while (!got && lat < 40) begin
          @(negedge clk);
          lat++;
          if (ram_enable) en++;
          if (p ? ack1 : ack0) begin
            got = 1;
            rd = p ? rdata1 : rdata0;
          end
        end
        if (!got) timeout_fail("access_ack", gi);
        req0 = 0; req1 = 0;
        @(negedge clk);
      endtask

      initial begin : stim
        int lat, en, nack, cyc;
        logic [DATA_W-1:0] rd;
        bit seen;
        rst_n = 0; req0 = 1; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset held two cycles with req0 high: everything quiet.
        repeat (2) @(negedge clk);
        check("rst_ack0", gi, 32'(ack0), 32'd0);
        check("rst_busy", gi, 32'(busy), 32'd0);
        check("rst_en",   gi, 32'(ram_enable), 32'd0);
        check("rst_addr", gi, 32'(ram_addr), 32'd0);
        rst_n = 1; req0 = 0;
        @(negedge clk);

        // Contention after reset: alternates 0,1,0,1 (fixed priority: all 0).
        req0 = 1; we0 = 0; addr0 = 12'h001;
        req1 = 1; we1 = 1; addr1 = 12'h005; wdata1 = 4'h9;
        nack = 0; cyc = 0;
        while (nack < 4 && cyc < 100) begin
          @(negedge clk);
          cyc++;
          if (ack0 || ack1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            check("grant_order", gi, 32'(ack1), 32'd0);
`else
            check("grant_order", gi, 32'(ack1), 32'(nack % 2));
`endif
            nack++;
          end
        end
        if (nack < 4) timeout_fail("grant_order", gi);
        req0 = 0; req1 = 0;
        repeat (2) @(negedge clk);

        // Write 0x5 to 0x002 then read it back on port 0.
        access(0, 1, 12'h002, 4'h5, lat, en, rd);
        check("wr_latency", gi, 32'(lat), 32'(AC + 1));
        check("wr_en_cycles", gi, 32'(en), 32'(AC));
        access(0, 0, 12'h002, 4'h0, lat, en, rd);
        check("rd_latency", gi, 32'(lat), 32'(AC + 1));
        check("rd_data", gi, 32'(rd), 32'h5);

        // Randomized traffic on both ports.
        repeat (1500) begin
          @(negedge clk);
          if (req0) begin
            if (ack0) begin
              if ($urandom_range(1, 0) == 0) req0 = 0;
              else begin we0 = 1'($urandom_range(1, 0)); addr0 = ADDR_W'($urandom_range(7, 0)); wdata0 = 4'($urandom_range(15, 0)); end
            end else if ($urandom_range(3, 0) == 0) begin
              we0 = 1'($urandom_range(1, 0)); addr0 = ADDR_W'($urandom_range(7, 0)); wdata0 = 4'($urandom_range(15, 0));
            end
          end else if ($urandom_range(2, 0) == 0) begin
            req0 = 1; we0 = 1'($urandom_range(1, 0)); addr0 = ADDR_W'($urandom_range(7, 0)); wdata0 = 4'($urandom_range(15, 0));
          end
          if (req1) begin
            if (ack1) begin
              if ($urandom_range(1, 0) == 0) req1 = 0;
              else begin we1 = 1'($urandom_range(1, 0)); addr1 = ADDR_W'($urandom_range(7, 0)); wdata1 = 4'($urandom_range(15, 0)); end
            end else if ($urandom_range(3, 0) == 0) begin
              we1 = 1'($urandom_range(1, 0)); addr1 = ADDR_W'($urandom_range(7, 0)); wdata1 = 4'($urandom_range(15, 0));
            end
          end else if ($urandom_range(2, 0) == 0) begin
            req1 = 1; we1 = 1'($urandom_range(1, 0)); addr1 = ADDR_W'($urandom_range(7, 0)); wdata1 = 4'($urandom_range(15, 0));
          end
        end
        req0 = 0; req1 = 0;
        repeat (AC + 4) @(negedge clk);

        // Reset during the ACCESS phase of a write aborts it with no ack.
        req0 = 1; we0 = 1; addr0 = 12'h004; wdata0 = 4'hA;
        seen = 0; cyc = 0;
        while (!seen && cyc < 10) begin
          @(negedge clk);
          cyc++;
          seen = ram_enable;
        end
        if (!seen) timeout_fail("abort_enable", gi);
        rst_n = 0; req0 = 0;
        @(negedge clk);
        check("abort_en",   gi, 32'(ram_enable), 32'd0);
        check("abort_we",   gi, 32'(ram_write_enable), 32'd0);
        check("abort_ack0", gi, 32'(ack0), 32'd0);
        check("abort_busy", gi, 32'(busy), 32'd0);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_busy", gi, 32'(busy), 32'd0);
        access(0, 0, 12'h004, 4'h0, lat, en, rd);
        check("post_rst_rd", gi, 32'(rd), 32'hA);
        lanes_done++;
      end
    end
  endgenerate

  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (lanes_done == 2) break;
    end
    if (lanes_done != 2) timeout_fail("bench_done", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
